// File: rtl/garduino_led_sequencer_if.sv
// Avalon-MM slave port bundle for the LED sequencer register block.
interface garduino_led_sequencer_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input  readdata);
   modport slave  (input  address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/garduino_led_sequencer.sv
// Avalon-MM LED sequencer: static / blink / rotate / bounce patterns on an 8-bit LED bank.
// Optional PWM dimming via DUTY in CTRL[11:4] when LED_SEQ_PWM_EN is defined.
module garduino_led_sequencer #(
   parameter int unsigned PERIOD_W       = 24,
   parameter int unsigned DEFAULT_PERIOD = 12500000
) (
   input  logic                           clk,
   input  logic                           reset_n,
   garduino_led_sequencer_if.slave        avs,
   output logic [7:0]                     out_port,
   output logic                           irq
);
   localparam int unsigned LED_W  = 8;
   localparam int unsigned STEP_W = 3;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PATTERN = 2'd1;
   localparam logic [1:0] ADDR_PERIOD = 2'd2;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_BLINK  = 2'd1,
      MODE_ROTATE = 2'd2,
      MODE_BOUNCE = 2'd3
   } mode_e;

   logic                en_q, en_d;
   mode_e               mode_q, mode_d;
   logic                irq_en_q, irq_en_d;
   logic [LED_W-1:0]    pattern_q, pattern_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic                blink_q, blink_d;
   logic [LED_W-1:0]    rot_q, rot_d;
   logic                dir_q, dir_d;
   logic                wrap_q, wrap_d;
   logic                irq_q, irq_d;
   logic [LED_W-1:0]    out_q, out_d;

   logic                wr, wr_ctrl, wr_pat, wr_per, wr_stat, restart, tick, wrap_set;
   logic [PERIOD_W-1:0] peff_m1;
   logic [LED_W-1:0]    frame;
   logic                unused_wdata;

   assign unused_wdata = ^avs.writedata;

`ifdef LED_SEQ_PWM_EN
   logic [7:0] duty_q, duty_d;
   logic [7:0] pwm_q, pwm_d;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_q      <= 1'b0;
         mode_q    <= MODE_STATIC;
         irq_en_q  <= 1'b0;
         pattern_q <= '0;
         period_q  <= PERIOD_W'(DEFAULT_PERIOD);
         cnt_q     <= '0;
         step_q    <= '0;
         blink_q   <= 1'b0;
         rot_q     <= '0;
         dir_q     <= 1'b0;
         wrap_q    <= 1'b0;
         irq_q     <= 1'b0;
         out_q     <= '0;
`ifdef LED_SEQ_PWM_EN
         duty_q    <= 8'hFF;
         pwm_q     <= '0;
`endif
      end else begin
         en_q      <= en_d;
         mode_q    <= mode_d;
         irq_en_q  <= irq_en_d;
         pattern_q <= pattern_d;
         period_q  <= period_d;
         cnt_q     <= cnt_d;
         step_q    <= step_d;
         blink_q   <= blink_d;
         rot_q     <= rot_d;
         dir_q     <= dir_d;
         wrap_q    <= wrap_d;
         irq_q     <= irq_d;
         out_q     <= out_d;
`ifdef LED_SEQ_PWM_EN
         duty_q    <= duty_d;
         pwm_q     <= pwm_d;
`endif
      end
   end

   // Register writes, prescaler, sequence stepping and next frame
   always_comb begin
      en_d      = en_q;
      mode_d    = mode_q;
      irq_en_d  = irq_en_q;
      pattern_d = pattern_q;
      period_d  = period_q;
      cnt_d     = cnt_q;
      step_d    = step_q;
      blink_d   = blink_q;
      rot_d     = rot_q;
      dir_d     = dir_q;
      wrap_d    = wrap_q;
      wrap_set  = 1'b0;
      frame     = '0;
      out_d     = '0;
`ifdef LED_SEQ_PWM_EN
      duty_d    = duty_q;
      pwm_d     = en_q ? pwm_q + 8'd1 : pwm_q;
`endif

      wr      = avs.chipselect & ~avs.write_n;
      wr_ctrl = wr && (avs.address == ADDR_CTRL);
      wr_pat  = wr && (avs.address == ADDR_PATTERN);
      wr_per  = wr && (avs.address == ADDR_PERIOD);
      wr_stat = wr && (avs.address == 2'd3);
      restart = wr_ctrl | wr_pat;

      if (wr_ctrl) begin
         en_d     = avs.writedata[0];
         mode_d   = mode_e'(avs.writedata[2:1]);
         irq_en_d = avs.writedata[3];
`ifdef LED_SEQ_PWM_EN
         duty_d   = avs.writedata[11:4];
`endif
      end
      if (wr_pat) pattern_d = avs.writedata[LED_W-1:0];
      if (wr_per) period_d  = avs.writedata[PERIOD_W-1:0];

      // ">=" so a shortened period ticks on the very next cycle
      peff_m1 = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
      tick    = en_q && (cnt_q >= peff_m1);

      if (!en_q || tick) cnt_d = '0;
      else               cnt_d = cnt_q + PERIOD_W'(1);

      if (restart) begin
         cnt_d   = '0;
         step_d  = '0;
         blink_d = 1'b0;
         dir_d   = 1'b0;
         rot_d   = pattern_d;
      end else if (tick) begin
         unique case (mode_q)
            MODE_BLINK: begin
               blink_d  = ~blink_q;
               wrap_set = blink_q;
            end
            MODE_ROTATE: begin
               rot_d    = {rot_q[LED_W-2:0], rot_q[LED_W-1]};
               step_d   = step_q + STEP_W'(1);
               wrap_set = (step_q == STEP_W'(7));
            end
            MODE_BOUNCE: begin
               if (!dir_q) begin
                  step_d = step_q + STEP_W'(1);
                  if (step_q == STEP_W'(6)) dir_d = 1'b1;
               end else begin
                  step_d = step_q - STEP_W'(1);
                  if (step_q == STEP_W'(1)) begin
                     dir_d    = 1'b0;
                     wrap_set = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      // Set beats a same-cycle W1C clear
      if (wr_stat && avs.writedata[1]) wrap_d = 1'b0;
      if (wrap_set)                    wrap_d = 1'b1;

      unique case (mode_d)
         MODE_STATIC: frame = pattern_d;
         MODE_BLINK:  frame = blink_d ? '0 : pattern_d;
         MODE_ROTATE: frame = rot_d;
         MODE_BOUNCE: frame = LED_W'(1) << step_d;
         default:     frame = '0;
      endcase
      if (!en_d) frame = '0;

`ifdef LED_SEQ_PWM_EN
      out_d = frame & {LED_W{pwm_q < duty_d}};
`else
      out_d = frame;
`endif
      irq_d = wrap_q & irq_en_q;
   end

   // Zero-wait-state read mux
   always_comb begin
      unique case (avs.address)
`ifdef LED_SEQ_PWM_EN
         ADDR_CTRL:    avs.readdata = 32'({duty_q, irq_en_q, mode_q, en_q});
`else
         ADDR_CTRL:    avs.readdata = 32'({irq_en_q, mode_q, en_q});
`endif
         ADDR_PATTERN: avs.readdata = 32'(pattern_q);
         ADDR_PERIOD:  avs.readdata = 32'(period_q);
         default:      avs.readdata = 32'({step_q, 6'b0, wrap_q, en_q});
      endcase
   end

   assign out_port = out_q;
   assign irq      = irq_q;
endmodule
